// File: rtl/twelve_hour_clock_if.sv
// Time-set, alarm and time-display signals of the 12-hour BCD clock.
// The master side drives the controls; the slave side is the clock itself.
interface twelve_hour_clock_if;
  logic       tick;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_pm;
  logic       alarm_en;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm_pm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       load_err;
  logic       alarm;

  modport master (
    output tick, load, load_hh, load_mm, load_ss, load_pm,
    output alarm_en, alarm_hh, alarm_mm, alarm_pm,
    input  hh, mm, ss, pm, load_err, alarm
  );

  modport slave (
    input  tick, load, load_hh, load_mm, load_ss, load_pm,
    input  alarm_en, alarm_hh, alarm_mm, alarm_pm,
    output hh, mm, ss, pm, load_err, alarm
  );
endinterface

// File: rtl/twelve_hour_clock.sv
// BCD hh:mm:ss AM/PM counter advanced by a 1 Hz enable pulse, with a
// range-checked time-set path and a single-shot alarm comparator.
module twelve_hour_clock #(
  parameter bit ALARM_ON_LOAD = 1'b0
) (
  input logic             clk,
  input logic             reset,
  twelve_hour_clock_if.slave bus
);

  logic [7:0] hh_reg, hh_next;
  logic [7:0] mm_reg, mm_next;
  logic [7:0] ss_reg, ss_next;
  logic       pm_reg, pm_next;
  logic       load_err_reg, load_err_next;
  logic       alarm_reg, alarm_next;

  logic [8:0] ss_inc, mm_inc, hh_inc;
  logic       hour_carry;
  logic [5:0] nib_ok;
  logic       load_ok;
  logic       fire_ok;
  logic [23:0] load_time;

  // Returns {carry, next}: wraps to 00 with carry when v equals top.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top) begin
      return {1'b1, 8'h00};
    end
    if (v[3:0] == 4'd9) begin
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    end
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign load_time = {bus.load_hh, bus.load_mm, bus.load_ss};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_nib
      assign nib_ok[gi] = (load_time[gi*4 +: 4] <= 4'd9);
    end
  endgenerate

  assign load_ok = (&nib_ok)
                && (bus.load_hh != 8'h00) && (bus.load_hh <= 8'h12)
                && (bus.load_mm[7:4] <= 4'd5)
                && (bus.load_ss[7:4] <= 4'd5);

  always_comb begin
    ss_inc        = bcd_inc(ss_reg, 8'h59);
    mm_inc        = bcd_inc(mm_reg, 8'h59);
    hh_inc        = bcd_inc(hh_reg, 8'hFF);
    hour_carry    = ss_inc[8] & mm_inc[8];
    hh_next       = hh_reg;
    mm_next       = mm_reg;
    ss_next       = ss_reg;
    pm_next       = pm_reg;
    load_err_next = 1'b0;
    fire_ok       = 1'b0;

    // Load beats tick; a tick on a load edge is discarded even if the load is rejected.
    if (bus.load) begin
      if (load_ok) begin
        hh_next = bus.load_hh;
        mm_next = bus.load_mm;
        ss_next = bus.load_ss;
        pm_next = bus.load_pm;
        fire_ok = ALARM_ON_LOAD;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (bus.tick) begin
      ss_next = ss_inc[7:0];
      fire_ok = 1'b1;
      if (ss_inc[8]) begin
        mm_next = mm_inc[7:0];
      end
      if (hour_carry) begin
        hh_next = (hh_reg == 8'h12) ? 8'h01 : hh_inc[7:0];
        pm_next = pm_reg ^ (hh_reg == 8'h11);
      end
    end

    alarm_next = fire_ok && bus.alarm_en
              && ({hh_next, mm_next, ss_next, pm_next}
                  == {bus.alarm_hh, bus.alarm_mm, 8'h00, bus.alarm_pm});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hh_reg       <= 8'h12;
      mm_reg       <= 8'h00;
      ss_reg       <= 8'h00;
      pm_reg       <= 1'b0;
      load_err_reg <= 1'b0;
      alarm_reg    <= 1'b0;
    end else begin
      hh_reg       <= hh_next;
      mm_reg       <= mm_next;
      ss_reg       <= ss_next;
      pm_reg       <= pm_next;
      load_err_reg <= load_err_next;
      alarm_reg    <= alarm_next;
    end
  end

  assign bus.hh       = hh_reg;
  assign bus.mm       = mm_reg;
  assign bus.ss       = ss_reg;
  assign bus.pm       = pm_reg;
  assign bus.load_err = load_err_reg;
  assign bus.alarm    = alarm_reg;

endmodule

// File: doc/twelve_hour_clock.md
Name: twelve_hour_clock

Overview:
BCD 12-hour time-of-day counter (hh:mm:ss plus AM/PM). Sits directly downstream of the 1000 Hz-to-1 Hz divider and consumes its one-cycle OneHertz pulse as the advance enable. It adds a synchronous time-set path with range checking and a single-shot alarm comparator. All counting runs in the system clk domain; no derived clocks.

Parameters:
ALARM_ON_LOAD  0  1 = a successful load that lands exactly on the alarm time also fires alarm; 0 = only tick-driven advances fire alarm

Ports:
clk       input   1  system clock, all state updates on rising edge
reset     input   1  asynchronous, active-low (0 = reset asserted); deassertion is synchronised upstream
tick      input   1  one-cycle advance enable (OneHertz from the divider); advances time by one second
load      input   1  one-cycle time-set strobe
load_hh   input   8  BCD hours to load, legal 01..12
load_mm   input   8  BCD minutes to load, legal 00..59
load_ss   input   8  BCD seconds to load, legal 00..59
load_pm   input   1  AM/PM to load (1 = PM)
alarm_en  input   1  alarm comparator enable, level
alarm_hh  input   8  BCD alarm hours
alarm_mm  input   8  BCD alarm minutes
alarm_pm  input   1  alarm AM/PM
hh        output  8  current hours, BCD 01..12
mm        output  8  current minutes, BCD 00..59
ss        output  8  current seconds, BCD 00..59
pm        output  1  1 = PM
load_err  output  1  one-cycle pulse: last load was rejected
alarm     output  1  one-cycle alarm pulse

Behaviour:
- Reset (reset=0, asynchronous): hh=8'h12, mm=8'h00, ss=8'h00, pm=0, load_err=0, alarm=0. Reset takes effect immediately and overrides every other input. The first edge after release behaves normally.
- All outputs are registered. A tick or load sampled at edge N is visible on the outputs after edge N. Latency is 1 cycle.
- Priority per edge: reset > load > tick. When load=1 and tick=1 on the same edge, the load wins and that tick is dropped (not deferred).
- Tick advance, BCD per digit. The low nibble wraps 9->0 and carries to the high nibble; 09 -> 10 is mandatory, and 0A..0F must never appear.
  - ss: 59 -> 00 with carry into mm; otherwise ss+1.
  - mm: advances only on the ss carry; 59 -> 00 with carry into hh.
  - hh: advances only on the mm carry.
    - 11 -> 12 toggles pm.
    - 12 -> 01 with no pm change.
    - Otherwise hh+1.
  - Full rollover: 11:59:59 PM -> 12:00:00 AM, and 11:59:59 AM -> 12:00:00 PM.
- Load validation, all evaluated combinationally on the load edge:
  - Every nibble must be <= 9.
  - load_hh must be in 01..12.
  - load_mm and load_ss high nibble must be <= 5.
  - If valid: hh/mm/ss/pm take the load values and load_err=0.
  - If invalid: time is unchanged, load_err=1 for exactly one cycle, and the tick on that edge is still dropped.
- load_err is 0 on every edge without an invalid load.
- Alarm: compare the next-state time against {alarm_hh, alarm_mm, 8'h00, alarm_pm}.
  - alarm=1 for the cycle after a tick-driven update when alarm_en=1 and next-state matches.
  - Load-driven matches fire alarm only when ALARM_ON_LOAD=1.
  - Because seconds must equal 00, alarm fires at most once per 12-hour match.
  - Alarm inputs are not validated; an illegal alarm time simply never matches.
- alarm_en deasserted on the matching edge suppresses the pulse. There is no latching or re-arm state.
- Repeated ticks on consecutive cycles are legal: each one advances by one second.
- Idle (no tick, no load): all registers hold, and load_err=0, alarm=0.

Test Plan:
- Reset: assert reset=0 mid-count at 03:27:41 PM -> outputs read 12:00:00 AM, load_err=0, alarm=0 without waiting for a clk edge; after release with no tick the outputs hold.
- BCD carries: load 01:09:09 AM, one tick -> 01:09:10; load 01:59:59 AM, one tick -> 02:00:00 AM; a monitor flags any nibble >9 over 100k random ticks.
- Hour/PM wrap: load 11:59:59 AM, tick -> 12:00:00 PM; load 12:59:59 PM, tick -> 01:00:00 PM; load 11:59:59 PM, tick -> 12:00:00 AM.
- Load vs tick and validation:
  - load 05:30:00 PM with tick same edge -> exactly 05:30:00 PM.
  - load_hh=8'h13 -> time unchanged, load_err one-cycle pulse.
  - load_mm=8'h60 and load_ss=8'h0A each rejected the same way.
  - load_hh=8'h00 rejected.
- Alarm: alarm 07:00 AM, alarm_en=1, load 06:59:58 AM, two ticks -> alarm pulses exactly once at the edge showing 07:00:00 AM; with alarm_en=0 -> no pulse; with ALARM_ON_LOAD=0, load 07:00:00 AM -> no pulse; with ALARM_ON_LOAD=1 -> pulse.
- Full-day soak: start 12:00:00 AM, 86400 ticks -> returns to 12:00:00 AM with pm=0; a reference model matches every cycle; alarm fires exactly once with alarm_en=1.
